// File: rtl/shot_controller.sv
// -----------------------------------------------------------------------------
// shot_controller
//   Turn FSM for an 8x8 naval-battle board. It accepts a player coordinate on
//   a rising edge of FIRE and drives that cell onto the 64:1 board mux select.
//   It samples the returned cell bit and keeps a fired-cell map, shot and hit
//   counters, and the game-over/win status.
//
// Parameters
//   SHIP_CELLS : number of ship-occupied cells; this many hits wins (1..64)
//   MAX_SHOTS  : shot budget; this many valid shots without a win loses (1..64)
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous active-high reset
//   ROW[2:0]   in   target row (A..H = 0..7)
//   COL[2:0]   in   target column 0..7
//   FIRE       in   debounced, synchronous fire button (level)
//   HIT_IN     in   board mux output for the currently driven SEL
//   SEL[5:0]   out  cell select to the board mux, {ROW,COL}
//   BUSY       out  shot in flight (SELECT or SAMPLE)
//   HIT_LED    out  last shot hit a new ship cell
//   MISS_LED   out  last shot hit water
//   REPEAT_LED out  last shot targeted an already-fired cell
//   SHOTS[6:0] out  valid shots taken
//   HITS[6:0]  out  ship cells hit
//   GAME_OVER  out  game finished, FIRE ignored until reset
//   WIN        out  game finished by reaching SHIP_CELLS hits
// -----------------------------------------------------------------------------
module shot_controller #(
   parameter int SHIP_CELLS = 10,
   parameter int MAX_SHOTS  = 32
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] ROW,
   input  logic [2:0] COL,
   input  logic       FIRE,
   input  logic       HIT_IN,
   output logic [5:0] SEL,
   output logic       BUSY,
   output logic       HIT_LED,
   output logic       MISS_LED,
   output logic       REPEAT_LED,
   output logic [6:0] SHOTS,
   output logic [6:0] HITS,
   output logic       GAME_OVER,
   output logic       WIN
);

   localparam logic [6:0] SHIP_W = 7'(SHIP_CELLS);
   localparam logic [6:0] SHOT_W = 7'(MAX_SHOTS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_SAMPLE,
      S_WAIT_RELEASE,
      S_DONE
   } state_t;

   state_t      state_q;
   logic        fire_q;
   logic [5:0]  sel_q;
   logic [63:0] map_q;
   logic [6:0]  shots_q;
   logic [6:0]  hits_q;
   logic        busy_q;
   logic        hit_led_q;
   logic        miss_led_q;
   logic        rep_led_q;
   logic        game_over_q;
   logic        win_q;

   logic        fire_req;
   logic        cell_fired;
   logic [6:0]  shots_d;
   logic [6:0]  hits_d;
   logic        win_d;
   logic        lose_d;

   // One request per press: fire_q resets high so a button held through
   // reset release must be let go before it can fire.
   assign fire_req = FIRE & ~fire_q;

   // Post-update counts for a new (non-repeat) shot; end conditions are
   // judged on these so the final shot's own result counts.
   always_comb begin
      cell_fired = map_q[sel_q];
      shots_d    = shots_q + 7'd1;
      hits_d     = hits_q + {6'd0, HIT_IN};
      win_d      = (hits_d == SHIP_W);
      lose_d     = (shots_d == SHOT_W);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         fire_q      <= 1'b1;
         sel_q       <= 6'd0;
         map_q       <= 64'd0;
         shots_q     <= 7'd0;
         hits_q      <= 7'd0;
         busy_q      <= 1'b0;
         hit_led_q   <= 1'b0;
         miss_led_q  <= 1'b0;
         rep_led_q   <= 1'b0;
         game_over_q <= 1'b0;
         win_q       <= 1'b0;
      end else begin
         fire_q <= FIRE;
         case (state_q)
            S_IDLE: begin
               if (fire_req) begin
                  // Coordinate is captured here; later ROW/COL changes are ignored.
                  sel_q      <= {ROW, COL};
                  hit_led_q  <= 1'b0;
                  miss_led_q <= 1'b0;
                  rep_led_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_SELECT;
               end
            end
            // Give the board mux one full cycle of stable select.
            S_SELECT: begin
               state_q <= S_SAMPLE;
            end
            S_SAMPLE: begin
               busy_q <= 1'b0;
               if (cell_fired) begin
                  // Repeats never count and never end the game.
                  rep_led_q <= 1'b1;
                  state_q   <= S_WAIT_RELEASE;
               end else begin
                  map_q[sel_q] <= 1'b1;
                  shots_q      <= shots_d;
                  if (HIT_IN) begin
                     hits_q    <= hits_d;
                     hit_led_q <= 1'b1;
                  end else begin
                     miss_led_q <= 1'b1;
                  end
                  // A winning hit on the last budgeted shot is still a win.
                  if (win_d) begin
                     game_over_q <= 1'b1;
                     win_q       <= 1'b1;
                     state_q     <= S_DONE;
                  end else if (lose_d) begin
                     game_over_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     state_q <= S_WAIT_RELEASE;
                  end
               end
            end
            S_WAIT_RELEASE: begin
               if (!FIRE) begin
                  state_q <= S_IDLE;
               end
            end
            S_DONE: begin
               state_q <= S_DONE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign SEL        = sel_q;
   assign BUSY       = busy_q;
   assign HIT_LED    = hit_led_q;
   assign MISS_LED   = miss_led_q;
   assign REPEAT_LED = rep_led_q;
   assign SHOTS      = shots_q;
   assign HITS       = hits_q;
   assign GAME_OVER  = game_over_q;
   assign WIN        = win_q;

endmodule

// File: tb/tb_shot_controller.sv
// -----------------------------------------------------------------------------
// tb_shot_controller
//   Bench for shot_controller. Three instances share stimulus and a board
//   model (ship cells 9, 10 and 21): a default-parameter one, a 2-ship/2-shot
//   one for the win-on-last-shot case and a 3-shot one for the loss case.
//   Only the instance selected by dsel is observed in each phase; every phase
//   starts with a reset so the other instances' histories do not matter.
// -----------------------------------------------------------------------------
module tb_shot_controller;

   logic       CLK = 1'b0;
   logic       RST;
   logic [2:0] ROW;
   logic [2:0] COL;
   logic       FIRE;
   logic [63:0] board;

   logic [5:0] sel_a, sel_w, sel_l;
   logic       busy_a, busy_w, busy_l;
   logic       hl_a, hl_w, hl_l;
   logic       ml_a, ml_w, ml_l;
   logic       rl_a, rl_w, rl_l;
   logic [6:0] sh_a, sh_w, sh_l;
   logic [6:0] hi_a, hi_w, hi_l;
   logic       go_a, go_w, go_l;
   logic       wn_a, wn_w, wn_l;
   logic       hit_a, hit_w, hit_l;

   assign hit_a = board[sel_a];
   assign hit_w = board[sel_w];
   assign hit_l = board[sel_l];

   always #5 CLK = ~CLK;

   shot_controller u_a (
      .CLK(CLK), .RST(RST), .ROW(ROW), .COL(COL), .FIRE(FIRE), .HIT_IN(hit_a),
      .SEL(sel_a), .BUSY(busy_a), .HIT_LED(hl_a), .MISS_LED(ml_a), .REPEAT_LED(rl_a),
      .SHOTS(sh_a), .HITS(hi_a), .GAME_OVER(go_a), .WIN(wn_a)
   );

   shot_controller #(.SHIP_CELLS(2), .MAX_SHOTS(2)) u_w (
      .CLK(CLK), .RST(RST), .ROW(ROW), .COL(COL), .FIRE(FIRE), .HIT_IN(hit_w),
      .SEL(sel_w), .BUSY(busy_w), .HIT_LED(hl_w), .MISS_LED(ml_w), .REPEAT_LED(rl_w),
      .SHOTS(sh_w), .HITS(hi_w), .GAME_OVER(go_w), .WIN(wn_w)
   );

   shot_controller #(.SHIP_CELLS(10), .MAX_SHOTS(3)) u_l (
      .CLK(CLK), .RST(RST), .ROW(ROW), .COL(COL), .FIRE(FIRE), .HIT_IN(hit_l),
      .SEL(sel_l), .BUSY(busy_l), .HIT_LED(hl_l), .MISS_LED(ml_l), .REPEAT_LED(rl_l),
      .SHOTS(sh_l), .HITS(hi_l), .GAME_OVER(go_l), .WIN(wn_l)
   );

   // Observed instance
   int         dsel;
   logic [5:0] o_sel;
   logic       o_busy, o_hl, o_ml, o_rl, o_go, o_wn;
   logic [6:0] o_sh, o_hi;

   always_comb begin
      o_sel = sel_a; o_busy = busy_a; o_hl = hl_a; o_ml = ml_a; o_rl = rl_a;
      o_sh = sh_a; o_hi = hi_a; o_go = go_a; o_wn = wn_a;
      case (dsel)
         1: begin
            o_sel = sel_w; o_busy = busy_w; o_hl = hl_w; o_ml = ml_w; o_rl = rl_w;
            o_sh = sh_w; o_hi = hi_w; o_go = go_w; o_wn = wn_w;
         end
         2: begin
            o_sel = sel_l; o_busy = busy_l; o_hl = hl_l; o_ml = ml_l; o_rl = rl_l;
            o_sh = sh_l; o_hi = hi_l; o_go = go_l; o_wn = wn_l;
         end
         default: ;
      endcase
   end

   typedef struct {
      logic       hit;
      logic       miss;
      logic       rep;
      logic [6:0] shots;
      logic [6:0] hits;
      logic       go;
      logic       win;
   } exp_t;

   typedef struct {
      logic [2:0] r;
      logic [2:0] c;
      exp_t       e;
   } vec_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
   endtask

   task automatic chk_result(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, " scoreboard_empty"}, 1, 0);
         return;
      end
      e = sb.pop_front();
      chk({tag, " HIT_LED"},    o_hl, e.hit);
      chk({tag, " MISS_LED"},   o_ml, e.miss);
      chk({tag, " REPEAT_LED"}, o_rl, e.rep);
      chk({tag, " SHOTS"},      o_sh, e.shots);
      chk({tag, " HITS"},       o_hi, e.hits);
      chk({tag, " GAME_OVER"},  o_go, e.go);
      chk({tag, " WIN"},        o_wn, e.win);
   endtask

   // One press: FIRE rises before edge n, result checked after edge n+2.
   task automatic shoot(input vec_t v, input string tag);
      @(negedge CLK);
      chk({tag, " BUSY_before"}, o_busy, 0);
      ROW = v.r; COL = v.c; FIRE = 1'b1;
      sb.push_back(v.e);
      @(posedge CLK); #1;
      chk({tag, " SEL"}, o_sel, {v.r, v.c});
      chk({tag, " BUSY_n"}, o_busy, 1);
      @(posedge CLK); #1;
      chk({tag, " BUSY_n1"}, o_busy, 1);
      @(posedge CLK); #1;
      chk({tag, " BUSY_n2"}, o_busy, 0);
      chk_result(tag);
      @(negedge CLK); FIRE = 1'b0;
      @(negedge CLK);
   endtask

   task automatic pulse_reset();
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK); RST = 1'b0;
      @(negedge CLK);
   endtask

   vec_t va[5];
   vec_t vw[2];
   vec_t vl[3];
   vec_t vh;
   vec_t vr;

   initial begin
      board = 64'd0;
      board[21] = 1'b1;
      board[9]  = 1'b1;
      board[10] = 1'b1;

      //            r     c      hit   miss  rep   shots  hits  go    win
      va[0] = '{3'd2, 3'd5, '{1'b1, 1'b0, 1'b0, 7'd1, 7'd1, 1'b0, 1'b0}};
      va[1] = '{3'd2, 3'd5, '{1'b0, 1'b0, 1'b1, 7'd1, 7'd1, 1'b0, 1'b0}};
      va[2] = '{3'd0, 3'd0, '{1'b0, 1'b1, 1'b0, 7'd2, 7'd1, 1'b0, 1'b0}};
      va[3] = '{3'd1, 3'd1, '{1'b1, 1'b0, 1'b0, 7'd3, 7'd2, 1'b0, 1'b0}};
      va[4] = '{3'd7, 3'd7, '{1'b0, 1'b1, 1'b0, 7'd4, 7'd2, 1'b0, 1'b0}};
      vh    = '{3'd1, 3'd2, '{1'b1, 1'b0, 1'b0, 7'd5, 7'd3, 1'b0, 1'b0}};
      vw[0] = '{3'd2, 3'd5, '{1'b1, 1'b0, 1'b0, 7'd1, 7'd1, 1'b0, 1'b0}};
      vw[1] = '{3'd1, 3'd1, '{1'b1, 1'b0, 1'b0, 7'd2, 7'd2, 1'b1, 1'b1}};
      vl[0] = '{3'd0, 3'd0, '{1'b0, 1'b1, 1'b0, 7'd1, 7'd0, 1'b0, 1'b0}};
      vl[1] = '{3'd0, 3'd1, '{1'b0, 1'b1, 1'b0, 7'd2, 7'd0, 1'b0, 1'b0}};
      vl[2] = '{3'd0, 3'd2, '{1'b0, 1'b1, 1'b0, 7'd3, 7'd0, 1'b1, 1'b0}};
      vr    = '{3'd0, 3'd0, '{1'b0, 1'b1, 1'b0, 7'd1, 7'd0, 1'b0, 1'b0}};

      dsel = 0;
      RST = 1'b1; FIRE = 1'b1; ROW = 3'd3; COL = 3'd3;
      repeat (3) @(posedge CLK);

      // Release reset with FIRE held: nothing may fire.
      @(negedge CLK); RST = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      chk("rst_hold SEL", o_sel, 0);
      chk("rst_hold BUSY", o_busy, 0);
      chk("rst_hold SHOTS", o_sh, 0);
      chk("rst_hold HITS", o_hi, 0);
      chk("rst_hold LEDS", {o_hl, o_ml, o_rl}, 0);
      chk("rst_hold GO_WIN", {o_go, o_wn}, 0);

      // Reset in the middle of a shot clears asynchronously.
      @(negedge CLK); FIRE = 1'b0;
      @(negedge CLK); ROW = 3'd2; COL = 3'd5; FIRE = 1'b1;
      @(posedge CLK); #1;
      chk("midrun BUSY_before_rst", o_busy, 1);
      chk("midrun SEL_before_rst", o_sel, 21);
      #2 RST = 1'b1;
      #1;
      chk("midrun SEL_async", o_sel, 0);
      chk("midrun BUSY_async", o_busy, 0);
      @(negedge CLK); RST = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      chk("midrun BUSY_after", o_busy, 0);
      chk("midrun SHOTS_after", o_sh, 0);
      chk("midrun LEDS_after", {o_hl, o_ml, o_rl}, 0);
      @(negedge CLK); FIRE = 1'b0;
      @(negedge CLK);

      // Main table: hit, repeat, miss, hit, miss.
      for (int i = 0; i < 5; i++) shoot(va[i], $sformatf("vecA%0d", i));

      // FIRE held 20 cycles with coordinates changing while busy.
      @(negedge CLK);
      ROW = vh.r; COL = vh.c; FIRE = 1'b1;
      sb.push_back(vh.e);
      @(posedge CLK); #1;
      chk("hold SEL", o_sel, 10);
      @(negedge CLK); ROW = 3'd7; COL = 3'd6;
      @(posedge CLK);
      @(negedge CLK); ROW = 3'd0; COL = 3'd0;
      @(posedge CLK); #1;
      chk_result("hold");
      for (int k = 0; k < 17; k++) begin
         @(negedge CLK); ROW = 3'(k); COL = 3'(k + 3);
      end
      @(posedge CLK); #1;
      chk("hold SHOTS_after", o_sh, 5);
      chk("hold HITS_after", o_hi, 3);
      chk("hold BUSY_after", o_busy, 0);
      chk("hold SEL_after", o_sel, 10);
      @(negedge CLK); FIRE = 1'b0;
      @(negedge CLK);

      // Win on the last budgeted shot, then DONE ignores FIRE.
      dsel = 1;
      pulse_reset();
      for (int i = 0; i < 2; i++) shoot(vw[i], $sformatf("vecW%0d", i));
      @(negedge CLK); ROW = 3'd0; COL = 3'd0; FIRE = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      chk("done SEL", o_sel, 9);
      chk("done BUSY", o_busy, 0);
      chk("done SHOTS", o_sh, 2);
      chk("done HITS", o_hi, 2);
      chk("done HIT_LED", o_hl, 1);
      chk("done GO_WIN", {o_go, o_wn}, 2'b11);
      @(negedge CLK); FIRE = 1'b0;
      @(negedge CLK);

      // Budget exhausted by misses, then reset out of DONE.
      dsel = 2;
      pulse_reset();
      for (int i = 0; i < 3; i++) shoot(vl[i], $sformatf("vecL%0d", i));
      @(negedge CLK); RST = 1'b1;
      #1;
      chk("lossrst GAME_OVER", o_go, 0);
      chk("lossrst SHOTS", o_sh, 0);
      chk("lossrst LEDS", {o_hl, o_ml, o_rl}, 0);
      @(negedge CLK); RST = 1'b0;
      @(negedge CLK);
      shoot(vr, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Safety net in case a wait is ever mis-sequenced.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

endmodule

// File: doc/shot_controller.md
Name: shot_controller

Overview:
- Turn FSM for the 8x8 naval-battle board.
- Accepts a player coordinate and a fire request, then drives the 6-bit cell select into the 64:1 board multiplexer.
- Samples the returned cell bit (1 = ship present) and keeps a 64-bit fired-cell map, shot and hit counters, and the game-over/win status.
- Sits between the input conditioning logic (debounced buttons/switches) and the board mux; it both feeds the mux select and consumes the mux output.

Parameters:
- SHIP_CELLS, 10, number of ship-occupied cells; reaching this many hits wins (1..64).
- MAX_SHOTS, 32, shot budget; after this many valid shots without a win the game is lost (1..64).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- ROW  input  3  target row, 0..7; board rows A..H.
- COL  input  3  target column, 0..7.
- FIRE  input  1  fire button; already debounced and synchronous to CLK; level.
- HIT_IN  input  1  board mux output for the currently driven SEL.
- SEL  output  6  cell select to the board mux. SEL[5:3] = ROW (mux S5..S3), SEL[2:0] = COL (mux S2..S0).
- BUSY  output  1  high while a shot is in flight (SELECT or SAMPLE).
- HIT_LED  output  1  last shot hit a new ship cell.
- MISS_LED  output  1  last shot hit water.
- REPEAT_LED  output  1  last shot targeted an already-fired cell.
- SHOTS  output  7  valid shots taken, 0..64.
- HITS  output  7  ship cells hit, 0..64.
- GAME_OVER  output  1  game finished; FIRE is ignored.
- WIN  output  1  set together with GAME_OVER when HITS reaches SHIP_CELLS.

Behaviour:
- Reset (asynchronous, immediate, valid from any state, including mid-shot):
  - State = IDLE.
  - SEL, counters, shot map, all LEDs, GAME_OVER and WIN = 0.
  - fire_q = 1, so a FIRE already held high at reset release does not fire.
- Fire request: fire_req = FIRE & ~fire_q, where fire_q is FIRE registered each cycle. One shot per press; holding FIRE never retriggers.
- States:
  - IDLE: on fire_req, latch {ROW,COL} into SEL, clear all three LEDs, go to SELECT. Otherwise hold.
  - SELECT: SEL is stable to the mux for one full cycle; go to SAMPLE unconditionally.
  - SAMPLE: let idx = SEL.
    - If map[idx] = 1: set REPEAT_LED only; counters and map unchanged.
    - Else: set map[idx], SHOTS += 1, then:
      - HIT_IN = 1: HITS += 1, HIT_LED = 1.
      - HIT_IN = 0: MISS_LED = 1.
    - Next state is DONE if any end condition below holds, otherwise WAIT_RELEASE.
  - End conditions, evaluated on the post-update counts:
    - New HITS == SHIP_CELLS: GAME_OVER = 1, WIN = 1. The win takes priority when the final budgeted shot is also the winning hit.
    - Else new SHOTS == MAX_SHOTS: GAME_OVER = 1, WIN = 0.
  - WAIT_RELEASE: return to IDLE once FIRE = 0.
  - DONE: terminal. All outputs hold and FIRE is ignored until RST.
- Latency: FIRE first sampled high at edge n → SEL valid after edge n. HIT_IN is sampled at edge n+2, and LEDs, counters and flags are valid after edge n+2. BUSY is high after edges n and n+1 only.
- ROW/COL changes while BUSY have no effect; the coordinate is latched at acceptance.
- HIT_IN is only sampled in SAMPLE.
- LEDs are one-hot or all zero, hold until the next accepted shot, and stay valid in DONE.
- SHOTS/HITS are 7-bit and cannot exceed 64 because the map blocks repeats. No wrap handling is needed.
- A repeat shot never triggers an end condition.
- Shot map is a 64-bit register bank indexed by {ROW,COL}.

Test Plan:
- Assert RST mid-run, then release with FIRE held high → all outputs 0, state IDLE, no shot until FIRE falls and rises again.
- Board model with cell 21 = 1; ROW=2, COL=5, pulse FIRE → SEL=21 one cycle after the press, HIT_LED=1, HITS=1, SHOTS=1 two cycles later; BUSY high for exactly 2 cycles.
- Fire at 21 again → REPEAT_LED=1, HIT_LED=0, SHOTS=1, HITS=1. Fire at water cell 0 → MISS_LED=1, SHOTS=2.
- Hold FIRE high 20 cycles, changing ROW/COL during BUSY → exactly one shot, at the coordinate present on the accepting edge.
- SHIP_CELLS=2, MAX_SHOTS=2, both shots on ship cells → second result gives GAME_OVER=1, WIN=1 (win beats exhausted budget); further FIRE presses change nothing.
- MAX_SHOTS=3 with three misses → GAME_OVER=1, WIN=0, SHOTS=3. Then assert RST while in DONE → all cleared and the map empty (the first cell shot again gives HIT/MISS, not REPEAT).
